// File: rtl/aurora_rst_pkg.sv
// Shared state encodings and per-state output decode for the Aurora reset sequencer.
package aurora_rst_pkg;

  typedef enum logic [2:0] {
    S_PMA       = 3'd0,
    S_WAIT_PLL  = 3'd1,
    S_WAIT_MMCM = 3'd2,
    S_PB_HOLD   = 3'd3,
    S_WAIT_CHAN = 3'd4,
    S_UP        = 3'd5
  } state_e;

  // Output vector layout: {pma_init, reset_pb, tx_clk_clr, link_ready}
  localparam logic [3:0] OUT_PMA       = 4'b1110;
  localparam logic [3:0] OUT_WAIT_PLL  = 4'b0110;
  localparam logic [3:0] OUT_WAIT_MMCM = 4'b0100;
  localparam logic [3:0] OUT_PB_HOLD   = 4'b0100;
  localparam logic [3:0] OUT_WAIT_CHAN = 4'b0000;
  localparam logic [3:0] OUT_UP        = 4'b0001;

  // Unknown encodings decode like S_PMA so the pins stay in the safe reset posture.
  function automatic logic [3:0] out_decode(input state_e st);
    case (st)
      S_PMA:       out_decode = OUT_PMA;
      S_WAIT_PLL:  out_decode = OUT_WAIT_PLL;
      S_WAIT_MMCM: out_decode = OUT_WAIT_MMCM;
      S_PB_HOLD:   out_decode = OUT_PB_HOLD;
      S_WAIT_CHAN: out_decode = OUT_WAIT_CHAN;
      S_UP:        out_decode = OUT_UP;
      default:     out_decode = OUT_PMA;
    endcase
  endfunction

endpackage

// File: rtl/aurora_rst_sync.sv
// Two-flop synchroniser bringing an asynchronous status bit into the init clock domain.
module aurora_rst_sync #(
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d_in,
  output logic d_out
);

  (* ASYNC_REG = "TRUE" *) logic meta_q;
  (* ASYNC_REG = "TRUE" *) logic sync_q;
  logic meta_d;
  logic sync_d;

  // Next-value selection for the two synchroniser stages.
  always_comb begin
    meta_d = d_in;
    sync_d = meta_q;
  end

  // Synchroniser flops; reset value is the "not ready" level of the signal.
  always_ff @(posedge clk) begin
    if (rst) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
    end
  end

  assign d_out = sync_q;

endmodule

// File: rtl/aurora_reset_sequencer.sv
// Aurora clocking/link bring-up sequencer in the INIT_CLK domain.
//
// state       | meaning
// ------------+-----------------------------------------------------------
// S_PMA       | hold PMA_INIT for PMA_INIT_CYCLES
// S_WAIT_PLL  | wait for GT PLL lock (bounded by LOCK_TIMEOUT_CYCLES)
// S_WAIT_MMCM | TX clock clear released, wait for MMCM lock (bounded)
// S_PB_HOLD   | keep RESET_PB high RESET_PB_CYCLES after MMCM lock
// S_WAIT_CHAN | RESET_PB released, wait for CHANNEL_UP (bounded)
// S_UP        | link ready; channel drop returns to S_WAIT_CHAN
module aurora_reset_sequencer
  import aurora_rst_pkg::*;
#(
  parameter int CNT_WIDTH              = 28,
  parameter int PMA_INIT_CYCLES        = 100000000,
  parameter int RESET_PB_CYCLES        = 128,
  parameter int LOCK_TIMEOUT_CYCLES    = 10000000,
  parameter int CHANNEL_TIMEOUT_CYCLES = 50000000,
  parameter int RETRY_WIDTH            = 8
) (
  input  logic                   INIT_CLK,
  input  logic                   INIT_RST,
  input  logic                   SOFT_RESET,
  input  logic                   GT_PLL_LOCKED,
  input  logic                   MMCM_NOT_LOCKED,
  input  logic                   CHANNEL_UP,
  output logic                   PMA_INIT,
  output logic                   RESET_PB,
  output logic                   TX_CLK_CLR,
  output logic                   LINK_READY,
  output logic [RETRY_WIDTH-1:0] RETRY_COUNT,
  output logic [2:0]             STATE
);

  localparam logic [CNT_WIDTH-1:0] PMA_LAST  = CNT_WIDTH'(PMA_INIT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] PB_LAST   = CNT_WIDTH'(RESET_PB_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] LOCK_LAST = CNT_WIDTH'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] CHAN_LAST = CNT_WIDTH'(CHANNEL_TIMEOUT_CYCLES - 1);

  logic gt_locked_s;
  logic mmcm_nl_s;
  logic chan_up_s;

  state_e                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d;
  logic [RETRY_WIDTH-1:0] retry_q, retry_d;
  logic [3:0]             out_q, out_d;
  logic                   fail;
  logic                   lock_lost;

  aurora_rst_sync #(.RST_VAL(1'b0)) u_sync_gt (
    .clk(INIT_CLK), .rst(INIT_RST), .d_in(GT_PLL_LOCKED), .d_out(gt_locked_s)
  );

  aurora_rst_sync #(.RST_VAL(1'b1)) u_sync_mmcm (
    .clk(INIT_CLK), .rst(INIT_RST), .d_in(MMCM_NOT_LOCKED), .d_out(mmcm_nl_s)
  );

  aurora_rst_sync #(.RST_VAL(1'b0)) u_sync_chan (
    .clk(INIT_CLK), .rst(INIT_RST), .d_in(CHANNEL_UP), .d_out(chan_up_s)
  );

  // Next-state, counter, retry and registered-output decode.
  always_comb begin
    state_d   = state_q;
    fail      = 1'b0;
    lock_lost = !gt_locked_s || mmcm_nl_s;

    if (SOFT_RESET) begin
      state_d = S_PMA;
    end else begin
      case (state_q)
        S_PMA: begin
          if (cnt_q == PMA_LAST) state_d = S_WAIT_PLL;
        end
        S_WAIT_PLL: begin
          if (gt_locked_s)             state_d = S_WAIT_MMCM;
          else if (cnt_q == LOCK_LAST) fail    = 1'b1;
        end
        S_WAIT_MMCM: begin
          if (!mmcm_nl_s)              state_d = S_PB_HOLD;
          else if (cnt_q == LOCK_LAST) fail    = 1'b1;
        end
        S_PB_HOLD: begin
          if (lock_lost)             fail    = 1'b1;
          else if (cnt_q == PB_LAST) state_d = S_WAIT_CHAN;
        end
        S_WAIT_CHAN: begin
          if (lock_lost)               fail    = 1'b1;
          else if (chan_up_s)          state_d = S_UP;
          else if (cnt_q == CHAN_LAST) fail    = 1'b1;
        end
        S_UP: begin
          if (lock_lost)       fail    = 1'b1;
          else if (!chan_up_s) state_d = S_WAIT_CHAN;
        end
        default: fail = 1'b1;
      endcase
    end

    if (fail) state_d = S_PMA;

    // Soft reset re-enters S_PMA even from S_PMA, so it restarts the count too.
    cnt_d   = (SOFT_RESET || (state_d != state_q)) ? '0 : cnt_q + CNT_WIDTH'(1);
    retry_d = (fail && (retry_q != '1)) ? retry_q + RETRY_WIDTH'(1) : retry_q;
    out_d   = out_decode(state_d);
  end

  // State, counter, retry and output registers share one edge so outputs track STATE.
  always_ff @(posedge INIT_CLK) begin
    if (INIT_RST) begin
      state_q <= S_PMA;
      cnt_q   <= '0;
      retry_q <= '0;
      out_q   <= OUT_PMA;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      retry_q <= retry_d;
      out_q   <= out_d;
    end
  end

  assign PMA_INIT    = out_q[3];
  assign RESET_PB    = out_q[2];
  assign TX_CLK_CLR  = out_q[1];
  assign LINK_READY  = out_q[0];
  assign RETRY_COUNT = retry_q;
  assign STATE       = state_q;

endmodule

// File: tb/tb_aurora_reset_sequencer.sv
// Directed bench for aurora_reset_sequencer with shortened phase/timeout lengths.
// All sampling and driving happens at the falling edge; a pin change made at a
// falling edge is first captured by the next rising edge, synchronised by the
// one after, and acted on by the FSM at the third, i.e. seen three falling
// edges later.
module tb_aurora_reset_sequencer;

  logic       clk;
  logic       INIT_RST;
  logic       SOFT_RESET;
  logic       GT_PLL_LOCKED;
  logic       MMCM_NOT_LOCKED;
  logic       CHANNEL_UP;
  logic       PMA_INIT;
  logic       RESET_PB;
  logic       TX_CLK_CLR;
  logic       LINK_READY;
  logic [7:0] RETRY_COUNT;
  logic [2:0] STATE;

  int errors = 0;
  int checks = 0;
  int n;

  aurora_reset_sequencer #(
    .CNT_WIDTH(28),
    .PMA_INIT_CYCLES(16),
    .RESET_PB_CYCLES(8),
    .LOCK_TIMEOUT_CYCLES(64),
    .CHANNEL_TIMEOUT_CYCLES(128),
    .RETRY_WIDTH(8)
  ) dut (
    .INIT_CLK(clk),
    .INIT_RST(INIT_RST),
    .SOFT_RESET(SOFT_RESET),
    .GT_PLL_LOCKED(GT_PLL_LOCKED),
    .MMCM_NOT_LOCKED(MMCM_NOT_LOCKED),
    .CHANNEL_UP(CHANNEL_UP),
    .PMA_INIT(PMA_INIT),
    .RESET_PB(RESET_PB),
    .TX_CLK_CLR(TX_CLK_CLR),
    .LINK_READY(LINK_READY),
    .RETRY_COUNT(RETRY_COUNT),
    .STATE(STATE)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycles(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Step falling edges until STATE reaches exp; n returns the edges taken.
  task automatic wait_state(input logic [2:0] exp, input int budget, output int cnt);
    cnt = 0;
    while (STATE !== exp && cnt < budget) begin
      @(negedge clk);
      cnt++;
    end
    chk("reach_state", {29'd0, STATE}, {29'd0, exp});
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_state"}, STATE, 0);
    chk({tag, "_pma"}, PMA_INIT, 1);
    chk({tag, "_pb"}, RESET_PB, 1);
    chk({tag, "_clr"}, TX_CLK_CLR, 1);
    chk({tag, "_lr"}, LINK_READY, 0);
    chk({tag, "_retry"}, RETRY_COUNT, 0);
  endtask

  initial begin
    INIT_RST        = 1'b1;
    SOFT_RESET      = 1'b0;
    GT_PLL_LOCKED   = 1'b0;
    MMCM_NOT_LOCKED = 1'b1;
    CHANNEL_UP      = 1'b0;

    cycles(3);
    chk_reset_outputs("reset");
    INIT_RST = 1'b0;

    // Nominal bring-up
    wait_state(3'd1, 40, n);
    chk("pma_len", n, 16);
    chk("pll_wait_pma", PMA_INIT, 0);
    chk("pll_wait_clr", TX_CLK_CLR, 1);
    chk("pll_wait_pb", RESET_PB, 1);
    cycles(3);
    GT_PLL_LOCKED = 1'b1;
    wait_state(3'd2, 10, n);
    chk("pll_lat", n, 3);
    chk("mmcm_wait_clr", TX_CLK_CLR, 0);
    chk("mmcm_wait_pb", RESET_PB, 1);
    cycles(2);
    MMCM_NOT_LOCKED = 1'b0;
    wait_state(3'd3, 10, n);
    chk("mmcm_lat", n, 3);
    wait_state(3'd4, 20, n);
    chk("pb_hold_len", n, 8);
    chk("chan_wait_pb", RESET_PB, 0);
    chk("chan_wait_lr", LINK_READY, 0);
    cycles(5);
    CHANNEL_UP = 1'b1;
    wait_state(3'd5, 10, n);
    chk("chan_lat", n, 3);
    chk("up_lr", LINK_READY, 1);
    chk("up_retry", RETRY_COUNT, 0);

    // Channel drop and recovery
    cycles(4);
    CHANNEL_UP = 1'b0;
    wait_state(3'd4, 10, n);
    chk("drop_lat", n, 3);
    chk("drop_lr", LINK_READY, 0);
    chk("drop_pb", RESET_PB, 0);
    chk("drop_retry", RETRY_COUNT, 0);
    CHANNEL_UP = 1'b1;
    wait_state(3'd5, 10, n);
    chk("relink_lat", n, 3);

    // MMCM lock loss in S_UP: 3-cycle pulse
    cycles(4);
    MMCM_NOT_LOCKED = 1'b1;
    cycles(2);
    chk("loss_not_yet", STATE, 5);
    cycles(1);
    MMCM_NOT_LOCKED = 1'b0;
    CHANNEL_UP      = 1'b0;
    chk("loss_state", STATE, 0);
    chk("loss_pma", PMA_INIT, 1);
    chk("loss_lr", LINK_READY, 0);
    chk("loss_retry", RETRY_COUNT, 1);

    // SOFT_RESET in S_PB_HOLD
    wait_state(3'd3, 40, n);
    cycles(2);
    SOFT_RESET = 1'b1;
    cycles(1);
    SOFT_RESET    = 1'b0;
    GT_PLL_LOCKED = 1'b0;
    chk("soft_state", STATE, 0);
    chk("soft_pma", PMA_INIT, 1);
    chk("soft_retry", RETRY_COUNT, 1);
    wait_state(3'd1, 40, n);
    chk("soft_pma_len", n, 16);

    // GT lock timeout, three passes
    wait_state(3'd0, 100, n);
    chk("pll_timeout_len", n, 64);
    chk("timeout1_retry", RETRY_COUNT, 2);
    chk("timeout1_pma", PMA_INIT, 1);
    wait_state(3'd1, 40, n);
    chk("pass2_pma_len", n, 16);
    wait_state(3'd0, 100, n);
    chk("timeout2_retry", RETRY_COUNT, 3);
    chk("timeout2_pma", PMA_INIT, 1);
    wait_state(3'd1, 40, n);
    wait_state(3'd0, 100, n);
    chk("timeout3_retry", RETRY_COUNT, 4);

    // SOFT_RESET on the same cycle as the lock timeout
    wait_state(3'd1, 40, n);
    cycles(63);
    chk("coincide_pre_state", STATE, 1);
    SOFT_RESET = 1'b1;
    cycles(1);
    SOFT_RESET = 1'b0;
    chk("coincide_state", STATE, 0);
    chk("coincide_retry", RETRY_COUNT, 4);
    wait_state(3'd1, 40, n);
    chk("coincide_pma_len", n, 16);

    // Drive the retry counter well past saturation
    for (int i = 0; i < 300; i++) begin
      wait_state(3'd0, 100, n);
      wait_state(3'd1, 40, n);
    end
    chk("sat_retry", RETRY_COUNT, 255);

    // INIT_RST during S_WAIT_CHAN
    GT_PLL_LOCKED = 1'b1;
    wait_state(3'd4, 60, n);
    chk("sat_hold_retry", RETRY_COUNT, 255);
    cycles(3);
    INIT_RST = 1'b1;
    cycles(1);
    chk_reset_outputs("midrst");
    INIT_RST = 1'b0;
    cycles(2);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
